// File: rtl/imem_loader.sv
// Instruction memory with a UART program loader: a little-endian length header followed by
// N 32-bit words is written into block RAM, while a registered read port serves the fetch stage.
module imem_loader #(
  parameter int unsigned IMEM_ADDR_W = 15,
  parameter logic [2:0]  MODE_LOAD   = 3'd1,
  parameter logic [2:0]  MODE_STALL  = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mode,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        done,
  output logic [31:0] word_count,
  output logic        overflow
);

  localparam logic [32:0] DepthW = 33'd1 << IMEM_ADDR_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLen  = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [31:0] mem [0:(1 << IMEM_ADDR_W) - 1];

  logic [1:0]  state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wc_q, wc_d;
  logic        ovf_q, ovf_d;
  logic [31:0] inst_q;
  logic [31:0] wdata;
  logic        we;

  // The current byte completes a word together with the three shifted-in bytes.
  assign wdata = {rx_data, asm_q};

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    wc_d       = wc_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    case (state_q)
      StIdle: begin
        if (mode == MODE_LOAD) begin
          state_d    = StLen;
          byte_idx_d = 2'd0;
          waddr_d    = 32'd0;
        end
      end
      StLen: begin
        if (mode != MODE_LOAD) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          asm_d      = {rx_data, asm_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            wc_d    = wdata;
            ovf_d   = {1'b0, wdata} > DepthW;
            state_d = (wdata == 32'd0) ? StDone : StData;
          end
        end
      end
      StData: begin
        if (mode != MODE_LOAD) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          asm_d      = {rx_data, asm_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            // Words past the end of memory are counted but never written, so no aliasing.
            we      = {1'b0, waddr_q} < DepthW;
            waddr_d = waddr_q + 32'd1;
            if (waddr_q + 32'd1 == wc_q) begin
              state_d = StDone;
            end
          end
        end
      end
      default: begin
        if (mode == MODE_STALL) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      waddr_q    <= 32'd0;
      wc_q       <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      waddr_q    <= waddr_d;
      wc_q       <= wc_d;
      ovf_q      <= ovf_d;
    end
  end

  // Plain write port without reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr_q[IMEM_ADDR_W-1:0]] <= wdata;
    end
  end

  // Read-first: a same-edge write to this address shows up on the following read.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= 32'd0;
    end else begin
      inst_q <= mem[pc[IMEM_ADDR_W+1:2]];
    end
  end

  logic unused_pc;
  assign unused_pc = ^{pc[31:IMEM_ADDR_W+2], pc[1:0]};

  assign inst       = inst_q;
  assign done       = (state_q == StDone);
  assign word_count = wc_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a transaction-level memory model and per-cycle compare.
module tb_imem_loader;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 1 << W;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        done;
  logic [31:0] word_count;
  logic        overflow;

  imem_loader #(.IMEM_ADDR_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pc         (pc),
    .inst       (inst),
    .done       (done),
    .word_count (word_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: memory image plus expected outputs after each edge.
  logic [31:0] mem_m [DEPTH];
  bit          mem_v [DEPTH];
  logic [31:0] exp_inst;
  bit          exp_inst_v;
  bit          exp_done;
  logic [31:0] exp_wc;
  bit          exp_ovf;
  bit          chk_en = 1'b0;
  bit          hold_pc = 1'b0;

  // Effects the driver announces for the coming edge.
  bit          p_rst, p_we, p_done_set, p_done_clr, p_hdr;
  int          p_waddr;
  logic [31:0] p_wdata, p_n;

  logic [31:0] words [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    if (p_rst) begin
      exp_inst   = 32'd0;
      exp_inst_v = 1'b1;
      exp_done   = 1'b0;
      exp_wc     = 32'd0;
      exp_ovf    = 1'b0;
    end else begin
      exp_inst   = mem_m[pc[W+1:2]];
      exp_inst_v = mem_v[pc[W+1:2]];
      if (p_we) begin
        mem_m[p_waddr] = p_wdata;
        mem_v[p_waddr] = 1'b1;
      end
      if (p_hdr) begin
        exp_wc  = p_n;
        exp_ovf = (p_n > DEPTH);
      end
      if (p_done_set) exp_done = 1'b1;
      if (p_done_clr) exp_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_inst_v) check("inst", inst, exp_inst);
      check("done", 32'(done), 32'(exp_done));
      check("word_count", word_count, exp_wc);
      check("overflow", 32'(overflow), 32'(exp_ovf));
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    p_rst = 0; p_we = 0; p_done_set = 0; p_done_clr = 0; p_hdr = 0;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (!hold_pc) pc = $urandom;
  endtask

  // Full or partial load of words[0..n-1]; ndata<0 sends every data byte.
  task automatic load(input logic [31:0] n, input int gmax, input int ndata);
    int sent = 0;
    mode = 3'd1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(gmax, 0)) cycle();
      rx_valid = 1'b1;
      rx_data  = n[8*k +: 8];
      if (k == 3) begin
        p_hdr = 1; p_n = n;
        if (n == 0) p_done_set = 1;
      end
      cycle();
    end
    for (int i = 0; i < int'(n); i++) begin
      for (int k = 0; k < 4; k++) begin
        if (ndata >= 0 && sent == ndata) return;
        repeat ($urandom_range(gmax, 0)) cycle();
        rx_valid = 1'b1;
        rx_data  = words[i][8*k +: 8];
        if (k == 3) begin
          if (i < int'(DEPTH)) begin
            p_we = 1; p_waddr = i; p_wdata = words[i];
          end
          if (i == int'(n) - 1) p_done_set = 1;
        end
        sent++;
        cycle();
      end
    end
  endtask

  task automatic to_idle();
    mode = 3'd0;
    p_done_clr = 1;
    cycle();
  endtask

  task automatic read_at(input logic [31:0] a, input logic [31:0] want, input string name);
    hold_pc = 1; pc = a;
    cycle();
    check(name, inst, want);
    hold_pc = 0;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem_v[i] = 1'b0;
    p_rst = 1; p_we = 0; p_done_set = 0; p_done_clr = 0; p_hdr = 0;
    rst = 1'b1; mode = 3'd0; rx_valid = 1'b0; rx_data = 8'd0; pc = 32'd0;
    chk_en = 1'b1;
    cycle();
    check("rst_inst", inst, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wc", word_count, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    cycle();

    // Basic load.
    words.delete(); words.push_back(32'h0000_0013); words.push_back(32'hDEAD_BEEF);
    load(2, 0, -1);
    check("basic_done", 32'(done), 32'd1);
    check("basic_wc", word_count, 32'd2);
    check("basic_ovf", 32'(overflow), 32'd0);
    mode = 3'd2;
    read_at(32'd4, 32'hDEAD_BEEF, "rd_pc4");
    read_at(32'd5, 32'hDEAD_BEEF, "rd_pc5");
    read_at(32'd4 + (32'd1 << (W + 2)), 32'hDEAD_BEEF, "rd_wrap");
    read_at(32'd0, 32'h0000_0013, "rd_pc0");
    check("exec_done", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      cycle();
    end
    to_idle();
    mode = 3'd3;
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      cycle();
    end

    // Zero length, then the basic load again with idle gaps.
    load(0, 0, -1);
    check("zero_done", 32'(done), 32'd1);
    check("zero_wc", word_count, 32'd0);
    to_idle();
    load(2, 20, -1);
    to_idle();
    read_at(32'd4, 32'hDEAD_BEEF, "gap_pc4");

    // Abort mid-word, then reload a single word.
    rand_words(3);
    load(3, 1, 6);
    mode = 3'd0;
    cycle();
    check("abort_done", 32'(done), 32'd0);
    read_at(32'd0, words[0], "abort_keep");
    words.delete(); words.push_back(32'h1122_3344);
    load(1, 3, -1);
    check("reload_done", 32'(done), 32'd1);
    read_at(32'd0, 32'h1122_3344, "reload_pc0");
    to_idle();

    // Write to word 0 while pc reads word 0.
    hold_pc = 1; pc = 32'd0;
    words.delete(); words.push_back(32'hCAFE_F00D);
    load(1, 0, -1);
    check("coll_old", inst, 32'h1122_3344);
    cycle();
    check("coll_new", inst, 32'hCAFE_F00D);
    hold_pc = 0;
    to_idle();

    // Exactly full, then overflowing by two words.
    rand_words(16);
    load(16, 0, -1);
    check("full_ovf", 32'(overflow), 32'd0);
    to_idle();
    rand_words(18);
    load(18, 1, -1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_wc", word_count, 32'd18);
    read_at(32'd0, words[0], "ovf_noalias0");
    read_at(32'd4, words[1], "ovf_noalias1");
    to_idle();

    // Reset in the middle of the data phase.
    rand_words(4);
    load(4, 0, 6);
    rst = 1'b1; mode = 3'd0; p_rst = 1;
    cycle();
    rst = 1'b0;
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_wc", word_count, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      cycle();
    end
    for (int a = 0; a < int'(DEPTH); a++) read_at(32'(a * 4), mem_m[a], "mrst_keep");

    // Random loads with occasional aborts.
    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(20, 0);
      rand_words(n);
      if (n > 0 && $urandom_range(3, 0) == 0) begin
        load(32'(n), 3, $urandom_range(4 * n - 1, 0));
        mode = 3'd0;
        cycle();
      end else begin
        load(32'(n), 3, -1);
        mode = 3'($urandom_range(3, 1));
        repeat (3) cycle();
        to_idle();
      end
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      hold_pc = 1; pc = $urandom; pc[W+1:2] = W'(a);
      cycle();
      hold_pc = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
